// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: frame tick decode, serve/play/point/game-over FSM and scoring.
// Optional pause state is built in when PONG_PAUSE_EN is defined.
module pong_game_ctrl #(
    parameter int FRAME_Y      = 524,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 30,
    parameter int WIN_SCORE    = 9
) (
    input  logic       clk_25,
    input  logic       rst_n,
    input  logic [9:0] sx,
    input  logic [9:0] sy,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       miss_l,
    input  logic       miss_r,
    output logic       ball_step,
    output logic       ball_center,
    output logic       serve_dir,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over,
    output logic       winner,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SERVE     = 3'd1,
        PLAY      = 3'd2,
        POINT     = 3'd3,
        GAME_OVER = 3'd4,
        PAUSE     = 3'd5
    } state_t;

    localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
    localparam int CW = $clog2(MAX_FRAMES + 1);
    localparam logic [CW-1:0] SERVE_LOAD = CW'(SERVE_FRAMES - 1);
    localparam logic [CW-1:0] POINT_LOAD = CW'(POINT_FRAMES - 1);
    localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          tick;
    logic          start_s1, start_s2, start_d, start_press;

    assign tick    = (sx == 10'd0) && (sy == 10'(FRAME_Y));
    assign state_o = state;

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            start_s1 <= 1'b0;
            start_s2 <= 1'b0;
            start_d  <= 1'b0;
        end else begin
            start_s1 <= start_btn;
            start_s2 <= start_s1;
            start_d  <= start_s2;
        end
    end
    assign start_press = start_s2 & ~start_d;

`ifdef PONG_PAUSE_EN
    logic pause_s1, pause_s2, pause_d, pause_press;

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            pause_s1 <= 1'b0;
            pause_s2 <= 1'b0;
            pause_d  <= 1'b0;
        end else begin
            pause_s1 <= pause_btn;
            pause_s2 <= pause_s1;
            pause_d  <= pause_s2;
        end
    end
    assign pause_press = pause_s2 & ~pause_d;
`else
    logic unused_pause;
    assign unused_pause = pause_btn;
`endif

    // Scores stop at the winning value rather than wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s >= WIN) ? s : s + 4'd1;
    endfunction

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            score_l     <= 4'd0;
            score_r     <= 4'd0;
            serve_dir   <= 1'b0;
            winner      <= 1'b0;
            ball_step   <= 1'b0;
            ball_center <= 1'b1;
            game_over   <= 1'b0;
        end else begin
            ball_step <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_press) begin
                        state   <= SERVE;
                        score_l <= 4'd0;
                        score_r <= 4'd0;
                        cnt     <= SERVE_LOAD;
                    end
                end
                SERVE: begin
                    if (tick) begin
                        if (cnt == '0) begin
                            state       <= PLAY;
                            ball_center <= 1'b0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                PLAY: begin
                    // The step for a tick fires even if a miss lands in that same cycle.
                    ball_step <= tick;
                    if (miss_l && miss_r) begin
                        state       <= SERVE;
                        cnt         <= SERVE_LOAD;
                        ball_center <= 1'b1;
                    end else if (miss_r) begin
                        score_l   <= sat_inc(score_l);
                        serve_dir <= 1'b0;
                        state     <= POINT;
                        cnt       <= POINT_LOAD;
                    end else if (miss_l) begin
                        score_r   <= sat_inc(score_r);
                        serve_dir <= 1'b1;
                        state     <= POINT;
                        cnt       <= POINT_LOAD;
`ifdef PONG_PAUSE_EN
                    end else if (pause_press) begin
                        state <= PAUSE;
`endif
                    end
                end
                POINT: begin
                    if (tick) begin
                        if (cnt == '0) begin
                            ball_center <= 1'b1;
                            if (score_l == WIN || score_r == WIN) begin
                                state     <= GAME_OVER;
                                game_over <= 1'b1;
                                winner    <= (score_r == WIN);
                            end else begin
                                state <= SERVE;
                                cnt   <= SERVE_LOAD;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                GAME_OVER: begin
                    if (start_press) begin
                        state     <= IDLE;
                        game_over <= 1'b0;
                    end
                end
`ifdef PONG_PAUSE_EN
                PAUSE: begin
                    if (pause_press) begin
                        state <= PLAY;
                    end
                end
`endif
                default: begin
                    state       <= IDLE;
                    ball_center <= 1'b1;
                    game_over   <= 1'b0;
                end
            endcase
        end
    end

endmodule
